digit_scan_mux: RTL and testbench

Time-multiplexed scanner for a multi-digit common-anode 7-segment display. Holds a multi-digit hex value, selects one 4-bit digit at a time at a programmable refresh rate, and presents it to the `digit_7seg` decoder together with active-low digit enables. Supports leading-zero blanking and tear-free value updates committed only at frame boundaries.

---
 rtl/digit_scan_mux.sv | 127 ++++++++++++
 tb/tb_digit_scan_mux.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Value updates are staged and committed only at the frame boundary to avoid tearing.
module digit_scan_mux #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  input  logic              blank_lz,
  output logic [3:0]        digit,
  output logic [NDIG-1:0]   an,
  output logic              frame,
  output logic              pending
);

  localparam int IDX_W = $clog2(NDIG);
  localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG - 1);

  logic [DIV_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [4*NDIG-1:0] r_shadow;
  logic [4*NDIG-1:0] r_pend_val;
  logic              r_pending;
  logic [3:0]        r_digit;
  logic [NDIG-1:0]   r_an;
  logic              r_frame;

  logic              w_tick;
  logic              w_wrap;
  logic [IDX_W-1:0]  w_idx_next;
  logic [4*NDIG-1:0] w_shadow_next;
  logic [NDIG-1:0]   w_nib_zero;
  logic [NDIG-1:0]   w_hi_zero;
  logic [3:0]        w_digit_next;
  logic [NDIG-1:0]   w_an_next;

  always_comb begin
    w_tick     = (r_cnt == CNT_MAX);
    w_wrap     = w_tick && (r_idx == IDX_MAX);
    w_idx_next = (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
  end

  // A load in the wrap cycle itself is newer than anything pending, so it wins.
  always_comb begin
    w_shadow_next = r_shadow;
    if (w_wrap) begin
      if (load) begin
        w_shadow_next = value;
      end else if (r_pending) begin
        w_shadow_next = r_pend_val;
      end
    end
  end

  // w_hi_zero[n]: nibbles n..NDIG-1 of the value about to be shown are all zero.
  for (genvar g = 0; g < NDIG; g++) begin : g_zero
    assign w_nib_zero[g] = (w_shadow_next[4*g +: 4] == 4'h0);
    assign w_hi_zero[g]  = &w_nib_zero[NDIG-1:g];
  end

  always_comb begin
    w_digit_next = '0;
    w_an_next    = '1;
    for (int n = 0; n < NDIG; n++) begin
      if (w_idx_next == IDX_W'(n)) begin
        w_digit_next = w_shadow_next[4*n +: 4];
        if (!(blank_lz && (n != 0) && w_hi_zero[n])) begin
          w_an_next[n] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= IDX_MAX;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= w_idx_next;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_pend_val <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_shadow <= w_shadow_next;
      if (load) begin
        r_pend_val <= value;
      end
      if (w_wrap) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
      r_an    <= '1;
      r_frame <= 1'b0;
    end else if (w_tick) begin
      r_digit <= w_digit_next;
      r_an    <= w_an_next;
      r_frame <= (w_idx_next == '0);
    end else begin
      r_frame <= 1'b0;
    end
  end

  assign digit   = r_digit;
  assign an      = r_an;
  assign frame   = r_frame;
  assign pending = r_pending;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with NDIG=4, DIV=4: table of display values
// plus hand-written sequences for reset, wrap-cycle load, last-load-wins, async reset.
module tb_digit_scan_mux;

  localparam int NDIG = 4;
  localparam int DIV  = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame;
  logic        pending;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0]     value;
    logic            blz;
    logic [3:0][3:0] dig;
    logic [3:0][3:0] an;
  } vec_t;

  vec_t vecs[7];
  logic [3:0][3:0] prev_dig;
  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  digit_scan_mux #(.NDIG(NDIG), .DIV(DIV), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .digit(digit), .an(an), .frame(frame), .pending(pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame !== 1'b1 && n < 64);
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame actual=timeout expected=frame_pulse");
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Called positioned at a frame pulse; checks all NDIG digit slots of that frame.
  task automatic check_frame(input logic [3:0][3:0] dig, input logic [3:0][3:0] ans);
    for (int k = 0; k < NDIG; k++) begin
      if (k > 0) repeat (DIV) step();
      exp_q.push_back(dig[k]);
      chk("frame_digit", digit, exp_q.pop_front());
      chk("frame_an", an, ans[k]);
      chk("frame_flag", frame, (k == 0));
    end
  endtask

  initial begin
    vecs[0] = '{value: 16'h1A2F, blz: 1'b0, dig: 16'h1A2F, an: AN_ALL};
    vecs[1] = '{value: 16'h0030, blz: 1'b1, dig: 16'h0030,
                an: {4'b1111, 4'b1111, 4'b1101, 4'b1110}};
    vecs[2] = '{value: 16'h0000, blz: 1'b1, dig: 16'h0000,
                an: {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
    vecs[3] = '{value: 16'h0000, blz: 1'b0, dig: 16'h0000, an: AN_ALL};
    vecs[4] = '{value: 16'h8001, blz: 1'b1, dig: 16'h8001, an: AN_ALL};
    vecs[5] = '{value: 16'h0400, blz: 1'b1, dig: 16'h0400,
                an: {4'b1111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[6] = '{value: 16'h0007, blz: 1'b1, dig: 16'h0007,
                an: {4'b1111, 4'b1111, 4'b1111, 4'b1110}};

    rst_n = 1'b0; value = '0; load = 1'b0; blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", an, 4'b1111);
    chk("rst_digit", digit, 4'h0);
    chk("rst_frame", frame, 1'b0);
    chk("rst_pending", pending, 1'b0);

    // Reset release and scan order
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pre_tick_an", an, 4'b1111);
      chk("pre_tick_frame", frame, 1'b0);
    end
    step();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] e_an;
      e_an = ~(4'b0001 << (i / 4));
      chk("scan_an", an, e_an);
      chk("scan_frame", frame, (i == 0));
      chk("scan_digit", digit, 4'h0);
      step();
    end
    chk("frame_period", frame, 1'b1);
    prev_dig = '0;

    // Table: load mid-frame, old frame stays intact, next frame shows new value
    for (int i = 0; i < 7; i++) begin
      wait_frame();
      chk("old_digit0", digit, prev_dig[0]);
      blank_lz = vecs[i].blz;
      pulse_load(vecs[i].value);
      chk("pending_set", pending, 1'b1);
      for (int k = 1; k < NDIG; k++) begin
        repeat (DIV) step();
        chk("old_digit", digit, prev_dig[k]);
        chk("pending_hold", pending, 1'b1);
      end
      wait_frame();
      chk("pending_clr", pending, 1'b0);
      check_frame(vecs[i].dig, vecs[i].an);
      prev_dig = vecs[i].dig;
    end

    // Load in the wrap-tick cycle overrides the pending value
    blank_lz = 1'b0;
    wait_frame();
    pulse_load(16'h1111);
    chk("wrap_pending_set", pending, 1'b1);
    repeat (14) step();
    pulse_load(16'h2222);
    chk("wrap_frame", frame, 1'b1);
    chk("wrap_pending", pending, 1'b0);
    check_frame(16'h2222, AN_ALL);
    step();
    chk("wrap_pending_after", pending, 1'b0);

    // Last load wins
    wait_frame();
    pulse_load(16'h5555);
    repeat (3) step();
    pulse_load(16'h6666);
    chk("lw_pending", pending, 1'b1);
    wait_frame();
    check_frame(16'h6666, AN_ALL);

    // Async reset during digit 2 with a load pending
    wait_frame();
    pulse_load(16'hABCD);
    repeat (2 * DIV - 1) step();
    chk("mid_an", an, 4'b1011);
    chk("mid_digit", digit, 4'h6);
    chk("mid_pending", pending, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'b1111);
    chk("async_pending", pending, 1'b0);
    chk("async_digit", digit, 4'h0);
    chk("async_frame", frame, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("rerst_an", an, 4'b1111);
    step();
    check_frame(16'h0000, AN_ALL);
    chk("rerst_pending", pending, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
